// File: rtl/phase_alu_pkg.sv
// phase_alu_pkg: shared definitions for the four-phase operand sequencer.
//   DEF_W / DEF_CW : default operand/result width and completed-round counter width
//   OP_*           : 2-bit opcode encodings captured alongside operand A
//   state_t        : sequencer states (IDLE, WAIT_B, WAIT_X, WAIT_W)
package phase_alu_pkg;

    localparam int unsigned DEF_W  = 8;
    localparam int unsigned DEF_CW = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_B,
        WAIT_X,
        WAIT_W
    } state_t;

endpackage

// File: rtl/phase_alu_ctrl_if.sv
// phase_alu_ctrl_if: bundle of phase, operand and result signals between the
// ring-counter side (master) and the sequencer/ALU (slave).
//   t0..t3       : timing phases from the ring counter
//   start        : round request, honoured on t0 while idle
//   op           : opcode, captured with operand A
//   din          : operand bus (A on t0, B on t1)
//   result/carry : registered ALU outputs
//   result_valid : one-cycle publish pulse
//   busy         : round in progress
//   phase_err    : sticky phase-fault flag
//   op_count     : completed rounds, wrapping
interface phase_alu_ctrl_if #(
    parameter int unsigned W  = phase_alu_pkg::DEF_W,
    parameter int unsigned CW = phase_alu_pkg::DEF_CW
);

    logic          t0;
    logic          t1;
    logic          t2;
    logic          t3;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  din;
    logic [W-1:0]  result;
    logic          carry;
    logic          result_valid;
    logic          busy;
    logic          phase_err;
    logic [CW-1:0] op_count;

    modport master (
        output t0, t1, t2, t3, start, op, din,
        input  result, carry, result_valid, busy, phase_err, op_count
    );

    modport slave (
        input  t0, t1, t2, t3, start, op, din,
        output result, carry, result_valid, busy, phase_err, op_count
    );

endinterface

// File: rtl/phase_alu.sv
// phase_alu: purely combinational ALU.
//   opr_i    : opcode (add, sub, and, xor)
//   a_i, b_i : operands
//   result_o : W-bit result
//   carry_o  : carry out of add, borrow out of sub (A < B), 0 for logic ops
module phase_alu
    import phase_alu_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic [1:0]   opr_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o,
    output logic         carry_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    // Top bit of the zero-extended difference is set exactly when A < B.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        unique case (opr_i)
            OP_ADD:  {carry_o, result_o} = sum;
            OP_SUB:  {carry_o, result_o} = diff;
            OP_AND:  result_o = a_i & b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/phase_alu_ctrl.sv
// phase_alu_ctrl: four-phase operand sequencer driven by a one-hot ring counter.
// Captures A/opcode on t0, B on t1, computes on t2, publishes on t3. Any phase
// pattern that is not exactly one-hot, or an unexpected phase mid-round, aborts
// the round and sets a sticky error.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : phase inputs, operands and result outputs (slave side)
module phase_alu_ctrl
    import phase_alu_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = DEF_CW
) (
    input  logic             clk,
    input  logic             rst,
    phase_alu_ctrl_if.slave  bus
);

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [1:0]    opr_q;
    logic [W-1:0]  result_q;
    logic          carry_q;
    logic          result_valid_q;
    logic          phase_err_q;
    logic [CW-1:0] op_count_q;

    logic [W-1:0]  alu_result;
    logic          alu_carry;
    logic          phase_ok;

    assign phase_ok = $onehot({bus.t3, bus.t2, bus.t1, bus.t0});

    phase_alu #(.W(W)) u_alu (
        .opr_i    (opr_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            opr_q          <= OP_ADD;
            result_q       <= '0;
            carry_q        <= 1'b0;
            result_valid_q <= 1'b0;
            phase_err_q    <= 1'b0;
            op_count_q     <= '0;
        end else begin
            result_valid_q <= 1'b0;
            if (!phase_ok) begin
                // Malformed phase vector aborts from any state, including IDLE.
                phase_err_q <= 1'b1;
                state_q     <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.t0 && bus.start) begin
                            a_q     <= bus.din;
                            opr_q   <= bus.op;
                            state_q <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (bus.t1) begin
                            b_q     <= bus.din;
                            state_q <= WAIT_X;
                        end else begin
                            phase_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    WAIT_X: begin
                        if (bus.t2) begin
                            result_q <= alu_result;
                            carry_q  <= alu_carry;
                            state_q  <= WAIT_W;
                        end else begin
                            phase_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    WAIT_W: begin
                        if (bus.t3) begin
                            result_valid_q <= 1'b1;
                            op_count_q     <= op_count_q + 1'b1;
                            state_q        <= IDLE;
                        end else begin
                            phase_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.carry        = carry_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.phase_err    = phase_err_q;
    assign bus.op_count     = op_count_q;

endmodule

// File: tb/tb_phase_alu_ctrl.sv
// tb_phase_alu_ctrl: self-checking bench for phase_alu_ctrl. Every cycle is
// compared against a behavioural model; table vectors and hand sequences add
// fixed expected values for the arithmetic and the corner cases.
module tb_phase_alu_ctrl;

    localparam int W  = 8;
    localparam int CW = 8;

    localparam logic [3:0] T0 = 4'b0001;
    localparam logic [3:0] T1 = 4'b0010;
    localparam logic [3:0] T2 = 4'b0100;
    localparam logic [3:0] T3 = 4'b1000;

    logic clk;
    logic rst;

    phase_alu_ctrl_if #(.W(W), .CW(CW)) bus ();

    phase_alu_ctrl #(.W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: m_next is the index of the phase the round is waiting
    // for next (-1 when no round is open).
    int m_next = -1;
    int m_a = 0, m_b = 0, m_op = 0;
    int m_res = 0, m_car = 0, m_valid = 0, m_err = 0, m_cnt = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_step(input logic [3:0] ph, input logic st, input logic [1:0] o,
                              input logic [7:0] d, input logic r);
        int s;
        if (r) begin
            m_next = -1; m_a = 0; m_b = 0; m_op = 0;
            m_res = 0; m_car = 0; m_valid = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_valid = 0;
            if ($countones(ph) != 1) begin
                m_err  = 1;
                m_next = -1;
            end else if (m_next < 0) begin
                if (ph[0] && st) begin
                    m_a = int'(d); m_op = int'(o); m_next = 1;
                end
            end else if (ph[m_next]) begin
                if (m_next == 1) begin
                    m_b = int'(d); m_next = 2;
                end else if (m_next == 2) begin
                    case (m_op)
                        0: begin s = m_a + m_b; m_res = s % 256; m_car = (s > 255) ? 1 : 0; end
                        1: begin m_res = (m_a - m_b + 256) % 256; m_car = (m_a < m_b) ? 1 : 0; end
                        2: begin m_res = m_a & m_b; m_car = 0; end
                        default: begin m_res = m_a ^ m_b; m_car = 0; end
                    endcase
                    m_next = 3;
                end else begin
                    m_valid = 1;
                    m_cnt   = (m_cnt + 1) % 256;
                    m_next  = -1;
                end
            end else begin
                m_err  = 1;
                m_next = -1;
            end
        end
    endtask

    task automatic cyc(input logic [3:0] ph, input logic st, input logic [1:0] o,
                       input logic [7:0] d, input logic r);
        bus.t0 = ph[0]; bus.t1 = ph[1]; bus.t2 = ph[2]; bus.t3 = ph[3];
        bus.start = st; bus.op = o; bus.din = d; rst = r;
        @(posedge clk);
        model_step(ph, st, o, d, r);
        #1;
        chk("m_result",    bus.result,       m_res);
        chk("m_carry",     bus.carry,        m_car);
        chk("m_valid",     bus.result_valid, m_valid);
        chk("m_busy",      bus.busy,         (m_next >= 0) ? 1 : 0);
        chk("m_phase_err", bus.phase_err,    m_err);
        chk("m_op_count",  bus.op_count,     m_cnt);
    endtask

    task automatic round(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        cyc(T0, 1'b1, o, a, 1'b0);
        cyc(T1, 1'b0, 2'b00, b, 1'b0);
        cyc(T2, 1'b0, 2'b00, 8'h5A, 1'b0);
        cyc(T3, 1'b0, 2'b00, 8'hA5, 1'b0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       car;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[1] = '{2'b01, 8'h05, 8'h0A, 8'hFB, 1'b1};
        vecs[2] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[3] = '{2'b11, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        vecs[4] = '{2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[5] = '{2'b00, 8'h10, 8'h20, 8'h30, 1'b0};

        // Reset state
        cyc(T0, 1'b1, 2'b00, 8'hFF, 1'b1);
        cyc(T1, 1'b0, 2'b00, 8'hFF, 1'b1);
        chk("rst_result", bus.result, 0);
        chk("rst_busy",   bus.busy,   0);
        chk("rst_count",  bus.op_count, 0);
        cyc(T2, 1'b0, 2'b00, 8'h00, 1'b0);
        cyc(T3, 1'b1, 2'b00, 8'h00, 1'b0);

        // Table rounds, back-to-back with start on every t0
        for (int i = 0; i < 6; i++) begin
            cyc(T0, 1'b1, vecs[i].op, vecs[i].a, 1'b0);
            chk("tbl_busy_t0", bus.busy, 1);
            chk("tbl_novalid_t0", bus.result_valid, 0);
            cyc(T1, 1'b0, 2'b00, vecs[i].b, 1'b0);
            cyc(T2, 1'b0, 2'b00, 8'h00, 1'b0);
            cyc(T3, 1'b0, 2'b00, 8'h00, 1'b0);
            chk("tbl_valid",  bus.result_valid, 1);
            chk("tbl_result", bus.result, vecs[i].res);
            chk("tbl_carry",  bus.carry, vecs[i].car);
            chk("tbl_count",  bus.op_count, i + 1);
            chk("tbl_idle",   bus.busy, 0);
        end

        // Phase fault in WAIT_B: t1 and t2 together
        cyc(T0, 1'b1, 2'b00, 8'h11, 1'b0);
        cyc(4'b0110, 1'b0, 2'b00, 8'h22, 1'b0);
        chk("flt_err",   bus.phase_err, 1);
        chk("flt_busy",  bus.busy, 0);
        chk("flt_valid", bus.result_valid, 0);
        chk("flt_count", bus.op_count, 6);
        chk("flt_result", bus.result, 8'h30);
        round(2'b00, 8'h01, 8'h02);
        chk("flt_clean_valid", bus.result_valid, 1);
        chk("flt_clean_result", bus.result, 8'h03);
        chk("flt_clean_count", bus.op_count, 7);
        chk("flt_sticky", bus.phase_err, 1);

        // Out-of-order t3 while waiting for t2
        cyc(T0, 1'b0, 2'b00, 8'h00, 1'b1);
        round(2'b11, 8'hAA, 8'h0F);
        chk("ooo_pre_result", bus.result, 8'hA5);
        chk("ooo_pre_err", bus.phase_err, 0);
        cyc(T0, 1'b1, 2'b01, 8'h40, 1'b0);
        cyc(T1, 1'b0, 2'b00, 8'h01, 1'b0);
        cyc(T3, 1'b0, 2'b00, 8'h00, 1'b0);
        chk("ooo_err",    bus.phase_err, 1);
        chk("ooo_busy",   bus.busy, 0);
        chk("ooo_result", bus.result, 8'hA5);
        chk("ooo_valid",  bus.result_valid, 0);

        // Reset while waiting for t2
        cyc(T0, 1'b1, 2'b00, 8'h33, 1'b0);
        cyc(T1, 1'b0, 2'b00, 8'h44, 1'b0);
        cyc(T2, 1'b0, 2'b00, 8'h00, 1'b1);
        chk("rx_result", bus.result, 0);
        chk("rx_err",    bus.phase_err, 0);
        chk("rx_count",  bus.op_count, 0);
        chk("rx_busy",   bus.busy, 0);
        cyc(T3, 1'b0, 2'b00, 8'h00, 1'b0);
        chk("rx_nopulse", bus.result_valid, 0);
        chk("rx_noerr",   bus.phase_err, 0);

        // Counter wrap after 2^CW rounds
        for (int i = 0; i < 255; i++)
            round(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        chk("wrap_pre", bus.op_count, 255);
        round(2'b00, 8'h01, 8'h01);
        chk("wrap_valid", bus.result_valid, 1);
        chk("wrap_count", bus.op_count, 0);

        // Randomised phases, starts, faults and resets against the model
        begin
            int k = 0;
            for (int i = 0; i < 1600; i++) begin
                logic [3:0] ph;
                ph = 4'b0001 << (k % 4);
                if ($urandom_range(0, 19) == 0) ph = 4'($urandom_range(0, 15));
                cyc(ph, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                    ($urandom_range(0, 149) == 0));
                k++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_alu_ctrl.md
# phase_alu_ctrl

Four-phase operand sequencer and ALU that sits directly downstream of the one-hot ring counter and consumes its timing phases t0..t3. Each round it captures operand A and an opcode on t0, captures operand B on t1, computes on t2, and publishes the result on t3. The block also checks that the incoming phases are well-formed, aborting and flagging an error if they are not. Rounds can run back-to-back, one every four clocks.

## Interface
- W, 8: operand/result width
- CW, 8: completed-operation counter width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- t0  input  1  phase 0 from ring counter
- t1  input  1  phase 1
- t2  input  1  phase 2
- t3  input  1  phase 3
- start  input  1  request a round; sampled only on t0 while IDLE
- op  input  2  opcode, captured with A: 00 add, 01 sub, 10 and, 11 xor
- din  input  W  operand bus; A on t0, B on t1
- result  output  W  registered ALU result
- carry  output  1  carry (add), borrow (sub), 0 (and/xor)
- result_valid  output  1  one-cycle pulse, result/carry newly published
- busy  output  1  high in any state other than IDLE
- phase_err  output  1  sticky phase-fault flag, cleared only by rst
- op_count  output  CW  completed rounds, wraps modulo 2^CW

## Operation
- One clock; reset is synchronous and active-high on rst. While rst=1 on an edge: state=IDLE, A=B=0, op reg=00, result=0, carry=0, result_valid=0, phase_err=0, op_count=0, busy=0.
- phase_ok = exactly one of t0..t3 high. Checked every non-reset edge regardless of state.
- State machine:
  - IDLE: on t0&start&phase_ok, A<=din, opr<=op, go WAIT_B.
  - WAIT_B: on t1 (phase_ok), B<=din, go WAIT_X.
  - WAIT_X: on t2, {carry,result}<=alu(opr,A,B), go WAIT_W.
  - WAIT_W: on t3, result_valid<=1, op_count<=op_count+1, go IDLE.
- Fault: !phase_ok in any state, or a phase other than the expected one in WAIT_B/WAIT_X/WAIT_W -> phase_err<=1, state<=IDLE, no result update, no result_valid, op_count unchanged. In IDLE, only !phase_ok is a fault.
- A phase fault blocks starting a round on that edge. A sticky phase_err does not block later rounds.
- ALU arithmetic: add = A+B, with carry as bit W of the (W+1)-bit sum. sub = A-B mod 2^W, with carry=1 iff A<B. and/xor: carry=0.
- result/carry hold their value until the next WAIT_X->WAIT_W transition.
- start outside IDLE, or outside t0, is ignored.

## Timing
- result_valid is registered. It is high for exactly the one cycle after the t3 edge, which coincides with the next t0.
- result/carry become valid one cycle after the t2 edge and are stable while result_valid is high.
- Latency: from the t0 capture edge to the result_valid high cycle is 4 clocks.
- Back-to-back: a start on the t0 that coincides with result_valid is accepted. Throughput is one round per 4 clocks.
- busy is combinational from state: high in the cycles after capture of A through the cycle containing t3.
- rst mid-round aborts immediately with no result_valid and no phase_err.
- op_count at 2^CW-1 wraps to 0 on completion.

## Structure
- Package phase_alu_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_AND/OP_XOR
  - state enum IDLE/WAIT_B/WAIT_X/WAIT_W
  - default W/CW constants
- Sub-module phase_alu: purely combinational. Inputs opr, A, B; outputs {carry, result}. Instantiated once in the top.
- The top holds the FSM, operand registers, phase checker, and counter.

## Test plan
- Add: A=8'h7F on t0, op=00, B=8'h01 on t1 -> result=8'h80, carry=0, single result_valid pulse in the cycle after t3, op_count=1.
- Sub with borrow: A=8'h05, B=8'h0A, op=01 -> result=8'hFB, carry=1. Then run A=8'hFF, B=8'h01, op=00 -> result=8'h00, carry=1.
- Back-to-back: start held high for 3 rounds (xor 8'hF0^8'h3C, and 8'hF0&8'h3C, add 8'h10+8'h20).
  - Required: result_valid every 4th cycle.
  - Results 8'hCC, 8'h30, 8'h30.
  - op_count=3.
- Phase fault: force t1 and t2 high together during WAIT_B.
  - Required: phase_err=1 next cycle, busy=0, no result_valid, op_count unchanged.
  - A following clean round still completes, and phase_err stays 1.
- Out-of-order: present t3 while in WAIT_X -> phase_err=1, return to IDLE, result unchanged.
- Reset/wrap:
  - Assert rst in WAIT_X -> all outputs 0 next cycle, no pulse.
  - Preload by running 2^CW rounds -> op_count wraps to 0.
